// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: load-use detection, EX operand forwarding selects,
// multi-cycle divider sequencing and a saturating stall counter for the
// 5-stage pipeline front end.
module pipe_hazard_ctrl #(
  parameter int DIV_CYCLES = 32
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_id_valid,
  input  logic [4:0]  i_id_rs,
  input  logic [4:0]  i_id_rt,
  input  logic        i_id_use_rs,
  input  logic        i_id_use_rt,
  input  logic        i_id_div,
  input  logic [4:0]  i_ex_rd,
  input  logic        i_ex_wreg,
  input  logic        i_ex_m2reg,
  input  logic [4:0]  i_mem_rd,
  input  logic        i_mem_wreg,
  input  logic        i_mem_m2reg,
  output logic        o_stall,
  output logic        o_bubble,
  output logic [1:0]  o_fwda,
  output logic [1:0]  o_fwdb,
  output logic        o_div_start,
  output logic        o_div_busy,
  output logic        o_div_done,
  output logic [31:0] o_stall_cnt
);

  // Forward select encodings
  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_EX  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;
  localparam logic [1:0] FWD_LD  = 2'b11;

  // Counter reload: RUN lasts cnt values DIV_CYCLES-1 down to 0
  localparam logic [7:0] CNT_LOAD = 8'(DIV_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [7:0]  r_cnt;
  logic [7:0]  w_cnt_nxt;
  logic [31:0] r_stall_cnt;

  logic        w_ex_hit_rs;
  logic        w_ex_hit_rt;
  logic        w_lu;
  logic        w_div_req;

  // Load-use: an EX load writing a register the ID instruction reads.
  // Register 0 is hardwired and never creates a dependency.
  always_comb begin
    w_ex_hit_rs = (i_ex_rd != 5'd0) && (i_ex_rd == i_id_rs);
    w_ex_hit_rt = (i_ex_rd != 5'd0) && (i_ex_rd == i_id_rt);
    w_lu        = i_id_valid && i_ex_wreg && i_ex_m2reg &&
                  ((i_id_use_rs && w_ex_hit_rs) || (i_id_use_rt && w_ex_hit_rt));
    w_div_req   = i_id_valid && i_id_div;
  end

  // Operand select for one source register; the younger EX result wins
  // over MEM. An EX load is never forwarded from EX (load-use stalls it).
  function automatic logic [1:0] fwd_sel(input logic [4:0] src);
    logic [1:0] sel;
    sel = FWD_RF;
    if (i_ex_wreg && !i_ex_m2reg && (i_ex_rd == src) && (i_ex_rd != 5'd0))
      sel = FWD_EX;
    else if (i_mem_wreg && (i_mem_rd == src) && (i_mem_rd != 5'd0))
      sel = i_mem_m2reg ? FWD_LD : FWD_MEM;
    return sel;
  endfunction

  // Forwarding selects for both EX operands
  always_comb begin
    o_fwda = fwd_sel(i_id_rs);
    o_fwdb = fwd_sel(i_id_rt);
  end

  // Sequencer next state and control outputs
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    o_stall     = 1'b0;
    o_bubble    = 1'b0;
    o_div_start = 1'b0;
    o_div_busy  = 1'b0;
    o_div_done  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_lu) begin
          // Hold ID one cycle so the load reaches MEM; a pending divide
          // waits and issues once its operands are forwardable.
          o_stall  = 1'b1;
          o_bubble = 1'b1;
        end else if (w_div_req) begin
          o_stall     = 1'b1;
          o_bubble    = 1'b1;
          o_div_start = 1'b1;
          w_cnt_nxt   = CNT_LOAD;
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        // Front end frozen for the divider latency; load-use is moot here
        o_stall    = 1'b1;
        o_bubble   = 1'b1;
        o_div_busy = 1'b1;
        w_cnt_nxt  = r_cnt - 8'd1;
        if (r_cnt == 8'd0) begin
          w_cnt_nxt   = 8'd0;
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        // The divide in ID advances now; its id_div must not restart
        o_div_done  = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = 8'd0;
      end
    endcase
  end

  // Sequencer state and latency counter
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_cnt   <= 8'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Saturating count of stalled cycles for performance monitoring
  always_ff @(posedge i_clk) begin
    if (i_rst)
      r_stall_cnt <= 32'd0;
    else if (o_stall && (r_stall_cnt != 32'hFFFF_FFFF))
      r_stall_cnt <= r_stall_cnt + 32'd1;
  end

  assign o_stall_cnt = r_stall_cnt;

endmodule
